program_sayaci_uretici: RTL and testbench

PROGRAM_SAYACI_URETICI -- requirements
Module: program_sayaci_uretici

---
 rtl/program_sayaci_uretici.sv | 170 +++++++++++++++++
 tb/tb_program_sayaci_uretici.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sayaci_uretici.sv
// rtl/program_sayaci_uretici.sv - fetch PC generator with in-order fetch queue and redirect drop counter
module program_sayaci_uretici #(
  parameter logic [31:0] BASLANGIC_PS    = 32'h4000_0000,
  parameter int          KUYRUK_DERINLIK = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        ongoru_aktif_o,
  input  logic        ongoru_gecerli_i,
  input  logic [31:0] atlanan_ps_i,
  input  logic        dallanma_hata_i,
  input  logic [31:0] duzeltilmis_ps_i,
  input  logic        durdur_i,
  output logic        getir_istek_o,
  output logic [31:0] getir_ps_o,
  input  logic        getir_hazir_i,
  input  logic        getir_yanit_gecerli_i,
  input  logic [31:0] getir_buyruk_i,
  output logic        buyruk_gecerli_o,
  output logic [31:0] buyruk_o,
  output logic [31:0] buyruk_ps_o,
  output logic        buyruk_ongoru_o
);

  localparam int AW = (KUYRUK_DERINLIK > 1) ? $clog2(KUYRUK_DERINLIK) : 1;
  localparam int PW = AW + 1;
  localparam int DW = 8;
  localparam logic [31:0] HIZA_MASKE = 32'hFFFF_FFFC;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  // An entry is filled exactly when it lies between bas (head) and dolum (fill).
  logic [PW-1:0] bas_q, bas_d;
  logic [PW-1:0] son_q, son_d;
  logic [PW-1:0] dolum_q, dolum_d;
  logic [DW-1:0] dusur_q, dusur_d;
  logic [31:0]   ps_q, ps_d;

  logic          gecerli_q, gecerli_d;
  logic [31:0]   buyruk_q, buyruk_d;
  logic [31:0]   buyruk_ps_q, buyruk_ps_d;
  logic          buyruk_ongoru_q, buyruk_ongoru_d;

  logic [31:0]   ps_mem     [KUYRUK_DERINLIK];
  logic          ongoru_mem [KUYRUK_DERINLIK];
  logic [31:0]   veri_mem   [KUYRUK_DERINLIK];

  logic [PW-1:0] sayi;
  logic [PW-1:0] bos_sayi;
  logic [DW-1:0] dusur_toplam;
  logic [AW-1:0] bas_idx;
  logic [AW-1:0] son_idx;
  logic [AW-1:0] dolum_idx;
  logic          kuyruk_dolu;
  logic          kabul;
  logic          yanit_al;
  logic          bas_dolu;
  logic          bas_hazir;
  logic          cek;

  assign sayi        = son_q - bas_q;
  assign bos_sayi    = son_q - dolum_q;
  assign bas_idx     = bas_q[AW-1:0];
  assign son_idx     = son_q[AW-1:0];
  assign dolum_idx   = dolum_q[AW-1:0];
  assign kuyruk_dolu = (sayi == PW'(KUYRUK_DERINLIK));

  assign getir_istek_o  = !rst_i && !dallanma_hata_i && !kuyruk_dolu;
  assign ongoru_aktif_o = getir_istek_o;
  assign getir_ps_o     = ps_q & HIZA_MASKE;
  assign kabul          = getir_istek_o && getir_hazir_i;

  assign yanit_al  = getir_yanit_gecerli_i && (dusur_q == '0) && (bos_sayi != '0) && !dallanma_hata_i;
  assign bas_dolu  = (dolum_q != bas_q);
  // A response landing on an unfilled head bypasses straight to the output register.
  assign bas_hazir = bas_dolu || yanit_al;
  assign cek       = bas_hazir && (!gecerli_q || !durdur_i) && !dallanma_hata_i;

  // Responses still in flight from an earlier flush are dropped ahead of the new ones.
  assign dusur_toplam = dusur_q + DW'(bos_sayi);

  always_comb begin
    ps_d    = ps_q;
    bas_d   = bas_q;
    son_d   = son_q;
    dolum_d = dolum_q;
    dusur_d = dusur_q;
    if (dallanma_hata_i) begin
      ps_d    = duzeltilmis_ps_i & HIZA_MASKE;
      bas_d   = '0;
      son_d   = '0;
      dolum_d = '0;
      if (getir_yanit_gecerli_i && (dusur_toplam != '0)) begin
        dusur_d = dusur_toplam - DW'(1);
      end else begin
        dusur_d = dusur_toplam;
      end
    end else begin
      if (kabul) begin
        ps_d  = ongoru_gecerli_i ? (atlanan_ps_i & HIZA_MASKE) : (ps_q + 32'd4);
        son_d = son_q + PW'(1);
      end
      if (yanit_al) begin
        dolum_d = dolum_q + PW'(1);
      end
      if (cek) begin
        bas_d = bas_q + PW'(1);
      end
      if (getir_yanit_gecerli_i && (dusur_q != '0)) begin
        dusur_d = dusur_q - DW'(1);
      end
    end
  end

  always_comb begin
    gecerli_d       = gecerli_q;
    buyruk_d        = buyruk_q;
    buyruk_ps_d     = buyruk_ps_q;
    buyruk_ongoru_d = buyruk_ongoru_q;
    if (dallanma_hata_i) begin
      gecerli_d = 1'b0;
    end else if (cek) begin
      gecerli_d       = 1'b1;
      buyruk_d        = bas_dolu ? veri_mem[bas_idx] : getir_buyruk_i;
      buyruk_ps_d     = ps_mem[bas_idx];
      buyruk_ongoru_d = ongoru_mem[bas_idx];
    end else if (!durdur_i) begin
      gecerli_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ps_q            <= BASLANGIC_PS;
      bas_q           <= '0;
      son_q           <= '0;
      dolum_q         <= '0;
      dusur_q         <= '0;
      gecerli_q       <= 1'b0;
      buyruk_q        <= '0;
      buyruk_ps_q     <= '0;
      buyruk_ongoru_q <= 1'b0;
    end else begin
      ps_q            <= ps_d;
      bas_q           <= bas_d;
      son_q           <= son_d;
      dolum_q         <= dolum_d;
      dusur_q         <= dusur_d;
      gecerli_q       <= gecerli_d;
      buyruk_q        <= buyruk_d;
      buyruk_ps_q     <= buyruk_ps_d;
      buyruk_ongoru_q <= buyruk_ongoru_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (kabul) begin
      ps_mem[son_idx]     <= getir_ps_o;
      ongoru_mem[son_idx] <= ongoru_gecerli_i;
    end
    if (yanit_al) begin
      veri_mem[dolum_idx] <= getir_buyruk_i;
    end
  end

  assign buyruk_gecerli_o = gecerli_q;
  assign buyruk_o         = buyruk_q;
  assign buyruk_ps_o      = buyruk_ps_q;
  assign buyruk_ongoru_o  = buyruk_ongoru_q;

endmodule

// File: tb/tb_program_sayaci_uretici.sv
// tb/tb_program_sayaci_uretici.sv - directed vector bench for program_sayaci_uretici
module tb_program_sayaci_uretici;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ongoru_aktif_o;
  logic        ongoru_gecerli_i;
  logic [31:0] atlanan_ps_i;
  logic        dallanma_hata_i;
  logic [31:0] duzeltilmis_ps_i;
  logic        durdur_i;
  logic        getir_istek_o;
  logic [31:0] getir_ps_o;
  logic        getir_hazir_i;
  logic        getir_yanit_gecerli_i;
  logic [31:0] getir_buyruk_i;
  logic        buyruk_gecerli_o;
  logic [31:0] buyruk_o;
  logic [31:0] buyruk_ps_o;
  logic        buyruk_ongoru_o;

  int kontrol_sayisi = 0;
  int hata_sayisi    = 0;

  program_sayaci_uretici #(
    .BASLANGIC_PS   (32'h4000_0000),
    .KUYRUK_DERINLIK(4)
  ) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .ongoru_aktif_o       (ongoru_aktif_o),
    .ongoru_gecerli_i     (ongoru_gecerli_i),
    .atlanan_ps_i         (atlanan_ps_i),
    .dallanma_hata_i      (dallanma_hata_i),
    .duzeltilmis_ps_i     (duzeltilmis_ps_i),
    .durdur_i             (durdur_i),
    .getir_istek_o        (getir_istek_o),
    .getir_ps_o           (getir_ps_o),
    .getir_hazir_i        (getir_hazir_i),
    .getir_yanit_gecerli_i(getir_yanit_gecerli_i),
    .getir_buyruk_i       (getir_buyruk_i),
    .buyruk_gecerli_o     (buyruk_gecerli_o),
    .buyruk_o             (buyruk_o),
    .buyruk_ps_o          (buyruk_ps_o),
    .buyruk_ongoru_o      (buyruk_ongoru_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        hz;
    logic        yv;
    logic [31:0] yb;
    logic        og;
    logic [31:0] ap;
    logic        dur;
    logic        e_ist;
    logic [31:0] e_ps;
    logic        e_gec;
    logic [31:0] e_b;
    logic [31:0] e_bps;
    logic        e_bong;
  } vek_t;

  vek_t tablo [12];

  function automatic vek_t v(input logic hz, input logic yv, input logic [31:0] yb,
                             input logic og, input logic [31:0] ap, input logic dur,
                             input logic e_ist, input logic [31:0] e_ps, input logic e_gec,
                             input logic [31:0] e_b, input logic [31:0] e_bps, input logic e_bong);
    vek_t r;
    r.hz = hz; r.yv = yv; r.yb = yb; r.og = og; r.ap = ap; r.dur = dur;
    r.e_ist = e_ist; r.e_ps = e_ps; r.e_gec = e_gec;
    r.e_b = e_b; r.e_bps = e_bps; r.e_bong = e_bong;
    return r;
  endfunction

  task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    kontrol_sayisi++;
    if (gercek !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s gercek=%h beklenen=%h", ad, gercek, beklenen);
    end
  endtask

  task automatic adim(input logic hz, input logic yv, input logic [31:0] yb,
                      input logic og, input logic [31:0] ap,
                      input logic hata, input logic [31:0] dp, input logic dur);
    getir_hazir_i         = hz;
    getir_yanit_gecerli_i = yv;
    getir_buyruk_i        = yb;
    ongoru_gecerli_i      = og;
    atlanan_ps_i          = ap;
    dallanma_hata_i       = hata;
    duzeltilmis_ps_i      = dp;
    durdur_i              = dur;
    #1;
  endtask

  task automatic tik();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    tablo[0]  = v(1, 0, 32'h0,  0, 32'h0,         0, 1, 32'h4000_0000, 0, 32'h0,  32'h0,         0);
    tablo[1]  = v(1, 0, 32'h0,  0, 32'h0,         0, 1, 32'h4000_0004, 0, 32'h0,  32'h0,         0);
    tablo[2]  = v(1, 0, 32'h0,  0, 32'h0,         0, 1, 32'h4000_0008, 0, 32'h0,  32'h0,         0);
    tablo[3]  = v(1, 0, 32'h0,  0, 32'h0,         0, 1, 32'h4000_000C, 0, 32'h0,  32'h0,         0);
    tablo[4]  = v(1, 0, 32'h0,  0, 32'h0,         0, 0, 32'h4000_0010, 0, 32'h0,  32'h0,         0);
    tablo[5]  = v(1, 1, 32'hA0, 0, 32'h0,         0, 0, 32'h4000_0010, 0, 32'h0,  32'h0,         0);
    tablo[6]  = v(1, 1, 32'hA1, 1, 32'h4000_0103, 0, 1, 32'h4000_0010, 1, 32'hA0, 32'h4000_0000, 0);
    tablo[7]  = v(0, 1, 32'hA2, 0, 32'h0,         0, 1, 32'h4000_0100, 1, 32'hA1, 32'h4000_0004, 0);
    tablo[8]  = v(0, 1, 32'hA3, 0, 32'h0,         0, 1, 32'h4000_0100, 1, 32'hA2, 32'h4000_0008, 0);
    tablo[9]  = v(0, 1, 32'hA4, 0, 32'h0,         0, 1, 32'h4000_0100, 1, 32'hA3, 32'h4000_000C, 0);
    tablo[10] = v(0, 0, 32'h0,  0, 32'h0,         0, 1, 32'h4000_0100, 1, 32'hA4, 32'h4000_0010, 1);
    tablo[11] = v(0, 0, 32'h0,  0, 32'h0,         0, 1, 32'h4000_0100, 0, 32'h0,  32'h0,         0);

    rst_i = 1'b1;
    adim(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk_i);
    kontrol("rst_istek",  {31'h0, getir_istek_o},    32'h0);
    kontrol("rst_gec",    {31'h0, buyruk_gecerli_o}, 32'h0);
    kontrol("rst_buyruk", buyruk_o,                  32'h0);
    kontrol("rst_bps",    buyruk_ps_o,               32'h0);
    kontrol("rst_bong",   {31'h0, buyruk_ongoru_o},  32'h0);
    tik();
    rst_i = 1'b0;

    // Fill to full, drain with one-cycle latency, predicted redirect.
    for (int i = 0; i < 12; i++) begin
      adim(tablo[i].hz, tablo[i].yv, tablo[i].yb, tablo[i].og, tablo[i].ap, 0, 32'h0, tablo[i].dur);
      kontrol($sformatf("T%0d_istek", i), {31'h0, getir_istek_o},    {31'h0, tablo[i].e_ist});
      kontrol($sformatf("T%0d_aktif", i), {31'h0, ongoru_aktif_o},   {31'h0, tablo[i].e_ist});
      kontrol($sformatf("T%0d_ps", i),    getir_ps_o,                tablo[i].e_ps);
      kontrol($sformatf("T%0d_gec", i),   {31'h0, buyruk_gecerli_o}, {31'h0, tablo[i].e_gec});
      if (tablo[i].e_gec) begin
        kontrol($sformatf("T%0d_buyruk", i), buyruk_o,                 tablo[i].e_b);
        kontrol($sformatf("T%0d_bps", i),    buyruk_ps_o,              tablo[i].e_bps);
        kontrol($sformatf("T%0d_bong", i),   {31'h0, buyruk_ongoru_o}, {31'h0, tablo[i].e_bong});
      end
      tik();
    end

    // Stall for five cycles while responses keep arriving.
    for (int i = 0; i < 4; i++) begin
      adim(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      kontrol("B_ps", getir_ps_o, 32'h4000_0100 + 32'(4 * i));
      tik();
    end
    adim(0, 1, 32'hB0, 0, 32'h0, 0, 32'h0, 0);
    kontrol("B_dolu_istek", {31'h0, getir_istek_o}, 32'h0);
    tik();
    for (int k = 0; k < 5; k++) begin
      adim(0, (k < 3), 32'hB1 + 32'(k), 0, 32'h0, 0, 32'h0, 1);
      kontrol("B_donuk_gec", {31'h0, buyruk_gecerli_o}, 32'h1);
      kontrol("B_donuk_b",   buyruk_o,    32'hB0);
      kontrol("B_donuk_bps", buyruk_ps_o, 32'h4000_0100);
      tik();
    end
    for (int k = 0; k < 4; k++) begin
      adim(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      kontrol("B_cik_gec", {31'h0, buyruk_gecerli_o}, 32'h1);
      kontrol("B_cik_b",   buyruk_o,    32'hB0 + 32'(k));
      kontrol("B_cik_bps", buyruk_ps_o, 32'h4000_0100 + 32'(4 * k));
      tik();
    end
    adim(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    kontrol("B_son_gec", {31'h0, buyruk_gecerli_o}, 32'h0);
    kontrol("B_son_ps",  getir_ps_o, 32'h4000_0110);
    tik();

    // Redirect with three unfilled entries and a same-cycle response.
    for (int i = 0; i < 3; i++) begin
      adim(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      kontrol("C_ps", getir_ps_o, 32'h4000_0110 + 32'(4 * i));
      tik();
    end
    adim(1, 1, 32'hDEAD, 0, 32'h0, 1, 32'h4000_0200, 0);
    kontrol("C_hata_istek", {31'h0, getir_istek_o}, 32'h0);
    tik();
    adim(1, 1, 32'hD1, 0, 32'h0, 0, 32'h0, 0);
    kontrol("C_ps_yeni", getir_ps_o, 32'h4000_0200);
    kontrol("C_istek",   {31'h0, getir_istek_o}, 32'h1);
    kontrol("C_gec1",    {31'h0, buyruk_gecerli_o}, 32'h0);
    tik();
    adim(0, 1, 32'hD2, 0, 32'h0, 0, 32'h0, 0);
    kontrol("C_ps2",  getir_ps_o, 32'h4000_0204);
    kontrol("C_gec2", {31'h0, buyruk_gecerli_o}, 32'h0);
    tik();
    adim(0, 1, 32'hC0, 0, 32'h0, 0, 32'h0, 0);
    kontrol("C_gec3", {31'h0, buyruk_gecerli_o}, 32'h0);
    tik();
    adim(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    kontrol("C_gec4", {31'h0, buyruk_gecerli_o}, 32'h1);
    kontrol("C_b",    buyruk_o,    32'hC0);
    kontrol("C_bps",  buyruk_ps_o, 32'h4000_0200);
    tik();
    adim(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    kontrol("C_gec5", {31'h0, buyruk_gecerli_o}, 32'h0);
    tik();

    // Address wrap, then redirect while output is held by a stall.
    adim(0, 0, 32'h0, 0, 32'h0, 1, 32'hFFFF_FFFF, 0);
    tik();
    adim(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    kontrol("D_ps_ust", getir_ps_o, 32'hFFFF_FFFC);
    kontrol("D_istek",  {31'h0, getir_istek_o}, 32'h1);
    tik();
    adim(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    kontrol("D_ps_sar", getir_ps_o, 32'h0000_0000);
    tik();
    adim(0, 1, 32'hE0, 0, 32'h0, 0, 32'h0, 0);
    tik();
    adim(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    kontrol("D_gec", {31'h0, buyruk_gecerli_o}, 32'h1);
    kontrol("D_b",   buyruk_o,    32'hE0);
    kontrol("D_bps", buyruk_ps_o, 32'hFFFF_FFFC);
    tik();
    adim(0, 0, 32'h0, 0, 32'h0, 1, 32'h4000_0300, 1);
    kontrol("D_donuk_gec", {31'h0, buyruk_gecerli_o}, 32'h1);
    tik();
    adim(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    kontrol("D_hata_gec", {31'h0, buyruk_gecerli_o}, 32'h0);
    kontrol("D_hata_ps",  getir_ps_o, 32'h4000_0300);
    tik();

    // Mid-operation reset with outstanding fetches.
    for (int i = 0; i < 2; i++) begin
      adim(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      tik();
    end
    rst_i = 1'b1;
    adim(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    kontrol("E_rst_istek", {31'h0, getir_istek_o}, 32'h0);
    tik();
    rst_i = 1'b0;
    adim(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    kontrol("E_ps",    getir_ps_o, 32'h4000_0000);
    kontrol("E_istek", {31'h0, getir_istek_o}, 32'h1);
    kontrol("E_gec",   {31'h0, buyruk_gecerli_o}, 32'h0);
    tik();
    adim(0, 1, 32'hF0, 0, 32'h0, 0, 32'h0, 0);
    tik();
    adim(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    kontrol("E_gec2", {31'h0, buyruk_gecerli_o}, 32'h1);
    kontrol("E_b",    buyruk_o,    32'hF0);
    kontrol("E_bps",  buyruk_ps_o, 32'h4000_0000);
    tik();

    $display("CHECKS %0d ERRORS %0d", kontrol_sayisi, hata_sayisi);
    $finish;
  end

endmodule
